// File: rtl/front_panel_ctrl.sv
// PDP-8 front-panel responder: debounced buttons -> CPU register loads, memory deposits, step/run.
// Optional examine path (btn_examine / mem_rdata / exam_data) enabled by defining PANEL_EXAMINE_EN.

module fp_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign rise = level_q & ~prev_q;
endmodule

module front_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_W          = 12,
  parameter int DATA_W          = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_load_pc,
  input  logic              btn_deposit,
  input  logic              btn_load_ac,
  input  logic              btn_step,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_run,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              pc_load,
  output logic              ac_load,
  output logic [DATA_W-1:0] ld_value,
  output logic              cpu_run,
  output logic              cpu_step,
  input  logic              cpu_instr_done,
`ifdef PANEL_EXAMINE_EN
  input  logic              btn_examine,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] exam_data,
`endif
  output logic [ADDR_W-1:0] panel_addr,
  output logic              busy
);
  localparam int B_LOAD_PC = 0;
  localparam int B_DEPOSIT = 1;
  localparam int B_LOAD_AC = 2;
  localparam int B_STEP    = 3;
`ifdef PANEL_EXAMINE_EN
  localparam int B_EXAMINE = 4;
  localparam int NUM_BTN   = 5;
`else
  localparam int NUM_BTN   = 4;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, MEM_WAIT, STEP_WAIT, RUN} state_t;

  logic [NUM_BTN-1:0] btn_raw, btn_rise;

`ifdef PANEL_EXAMINE_EN
  assign btn_raw = {btn_examine, btn_step, btn_load_ac, btn_deposit, btn_load_pc};
`else
  assign btn_raw = {btn_step, btn_load_ac, btn_deposit, btn_load_pc};
`endif

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    fp_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[g]),
      .rise   (btn_rise[g])
    );
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pa_q, pa_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   ld_value_q, ld_value_d;
  logic                ld_pc_q, ld_pc_d;
  logic                we_q, we_d;
  logic                step_q, step_d;
`ifdef PANEL_EXAMINE_EN
  logic [DATA_W-1:0]   exam_q, exam_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pa_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_value_q  <= '0;
      ld_pc_q     <= 1'b0;
      we_q        <= 1'b0;
      step_q      <= 1'b0;
`ifdef PANEL_EXAMINE_EN
      exam_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pa_q        <= pa_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_value_q  <= ld_value_d;
      ld_pc_q     <= ld_pc_d;
      we_q        <= we_d;
      step_q      <= step_d;
`ifdef PANEL_EXAMINE_EN
      exam_q      <= exam_d;
`endif
    end
  end

  // Events are honoured only from IDLE with run off; the if/else chain sets the priority.
  always_comb begin
    state_d     = state_q;
    pa_d        = pa_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_value_d  = ld_value_q;
    ld_pc_d     = ld_pc_q;
    we_d        = we_q;
    step_d      = 1'b0;
`ifdef PANEL_EXAMINE_EN
    exam_d      = exam_q;
`endif
    case (state_q)
      IDLE: begin
        if (sw_run) begin
          state_d = RUN;
        end else if (btn_rise[B_LOAD_PC]) begin
          ld_value_d = sw_data;
          pa_d       = ADDR_W'(sw_data);
          ld_pc_d    = 1'b1;
          state_d    = LOAD;
        end else if (btn_rise[B_DEPOSIT]) begin
          mem_addr_d  = pa_q;
          mem_wdata_d = sw_data;
          we_d        = 1'b1;
          state_d     = MEM_WAIT;
`ifdef PANEL_EXAMINE_EN
        end else if (btn_rise[B_EXAMINE]) begin
          mem_addr_d = pa_q;
          we_d       = 1'b0;
          state_d    = MEM_WAIT;
`endif
        end else if (btn_rise[B_LOAD_AC]) begin
          ld_value_d = sw_data;
          ld_pc_d    = 1'b0;
          state_d    = LOAD;
        end else if (btn_rise[B_STEP]) begin
          step_d  = 1'b1;
          state_d = STEP_WAIT;
        end
      end
      LOAD: state_d = IDLE;
      MEM_WAIT: begin
        if (mem_gnt) begin
          pa_d    = pa_q + 1'b1;
          state_d = IDLE;
`ifdef PANEL_EXAMINE_EN
          if (!we_q) exam_d = mem_rdata;
`endif
        end
      end
      STEP_WAIT: if (cpu_instr_done) state_d = IDLE;
      RUN:       if (!sw_run) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state_q == MEM_WAIT);
    mem_we   = (state_q == MEM_WAIT) & we_q;
    pc_load  = (state_q == LOAD) & ld_pc_q;
    ac_load  = (state_q == LOAD) & ~ld_pc_q;
    cpu_run  = (state_q == RUN);
    cpu_step = step_q;
    busy     = (state_q != IDLE);
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign ld_value   = ld_value_q;
  assign panel_addr = pa_q;
`ifdef PANEL_EXAMINE_EN
  assign exam_data  = exam_q;
`endif
endmodule
